// File: rtl/parser_input_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// parser_input_arbiter_pkg
// Shared types and helpers for the parser input arbiter:
//   state_e  - arbiter FSM states
//   qidx_t   - queue index (wide enough for up to 8 queues)
//   is_hdr() - a control word is a header/EOP marker when it is non-zero
// No ports (package).
// -----------------------------------------------------------------------------
package parser_input_arbiter_pkg;

    localparam int QIDX_W     = 3;
    // Widest ctrl field the helper accepts; callers zero-extend to this width.
    localparam int CTRL_MAX_W = 64;

    typedef logic [QIDX_W-1:0] qidx_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HDR   = 2'd1,
        ST_DATA  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    function automatic logic is_hdr(input logic [CTRL_MAX_W-1:0] ctrl);
        return |ctrl;
    endfunction

endpackage

// File: rtl/parser_input_arbiter_if.sv
// -----------------------------------------------------------------------------
// parser_input_arbiter_if
// Bundles the queue-side and parser-side signals of the input arbiter.
//   in_data/in_ctrl/in_valid : packed per-queue words presented by the queues
//   in_rdy                   : per-queue consume strobe from the arbiter
//   out_data/out_ctrl/out_wr : registered word stream into the parser
//   out_rdy                  : parser can absorb a word next cycle
//   out_src_port             : queue owning the current packet
//   pkt_err                  : one-cycle watchdog pulse
// Modports: master = queues + parser (environment), slave = arbiter.
// -----------------------------------------------------------------------------
interface parser_input_arbiter_if #(
    parameter int DATA_WIDTH  = 64,
    parameter int CTRL_WIDTH  = DATA_WIDTH / 8,
    parameter int NUM_QUEUES  = 4,
    parameter int NUM_IQ_BITS = 3
);
    logic [NUM_QUEUES*DATA_WIDTH-1:0] in_data;
    logic [NUM_QUEUES*CTRL_WIDTH-1:0] in_ctrl;
    logic [NUM_QUEUES-1:0]            in_valid;
    logic [NUM_QUEUES-1:0]            in_rdy;
    logic [DATA_WIDTH-1:0]            out_data;
    logic [CTRL_WIDTH-1:0]            out_ctrl;
    logic                             out_wr;
    logic                             out_rdy;
    logic [NUM_IQ_BITS-1:0]           out_src_port;
    logic                             pkt_err;

    modport master (
        output in_data, in_ctrl, in_valid, out_rdy,
        input  in_rdy, out_data, out_ctrl, out_wr, out_src_port, pkt_err
    );

    modport slave (
        input  in_data, in_ctrl, in_valid, out_rdy,
        output in_rdy, out_data, out_ctrl, out_wr, out_src_port, pkt_err
    );
endinterface

// File: rtl/parser_input_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// parser_input_arbiter_rr_pick
// Combinational round-robin selector: returns the first requesting queue
// strictly after last_i, wrapping modulo NUM_QUEUES.
//   req_i   : request vector, one bit per queue
//   last_i  : most recently granted queue
//   grant_o : chosen queue (last_i when nothing requests)
//   any_o   : at least one request present
// -----------------------------------------------------------------------------
module parser_input_arbiter_rr_pick
    import parser_input_arbiter_pkg::*;
#(
    parameter int NUM_QUEUES = 4
) (
    input  logic [NUM_QUEUES-1:0] req_i,
    input  qidx_t                 last_i,
    output qidx_t                 grant_o,
    output logic                  any_o
);

    always_comb begin
        logic  found;
        qidx_t pick;
        found = 1'b0;
        pick  = last_i;
        // Walk distances 1..NUM_QUEUES from last_i; distance NUM_QUEUES is
        // last_i itself, so a lone requester can be re-granted.
        for (int k = 1; k <= NUM_QUEUES; k++) begin
            for (int q = 0; q < NUM_QUEUES; q++) begin
                if (!found && req_i[q] && (q == (int'(last_i) + k) % NUM_QUEUES)) begin
                    found = 1'b1;
                    pick  = qidx_t'(q);
                end
            end
        end
        grant_o = pick;
        any_o   = found;
    end

endmodule

// File: rtl/parser_input_arbiter.sv
// -----------------------------------------------------------------------------
// parser_input_arbiter
// Packet-granular round-robin arbiter feeding the Ethernet parser. One queue
// owns the datapath from grant until its EOP word; words pass through
// unchanged with one cycle of latency. A per-packet word watchdog truncates
// runaway packets: after MAX_WORDS forwarded words the rest of the packet is
// consumed and dropped.
//   clk          : rising-edge clock
//   reset_n      : asynchronous active-low reset
//   bus (slave)  : queue inputs, parser outputs, out_src_port, pkt_err
// Framing: ctrl!=0 header words, first ctrl==0 word starts payload, next
// ctrl!=0 word after payload is EOP.
// -----------------------------------------------------------------------------
module parser_input_arbiter
    import parser_input_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int CTRL_WIDTH  = DATA_WIDTH / 8,
    parameter int NUM_QUEUES  = 4,
    parameter int NUM_IQ_BITS = 3,
    parameter int MAX_WORDS   = 256
) (
    input logic                   clk,
    input logic                   reset_n,
    parser_input_arbiter_if.slave bus
);

    localparam int               CNT_W   = $clog2(MAX_WORDS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WORDS);

    state_e                  state_q, state_d;
    qidx_t                   sel_q, sel_d;
    qidx_t                   last_q, last_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
    logic                    drain_pay_q, drain_pay_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic [CTRL_WIDTH-1:0]   out_ctrl_q, out_ctrl_d;
    logic                    out_wr_q, out_wr_d;
    logic                    pkt_err_q, pkt_err_d;

    logic [NUM_QUEUES-1:0]   sel_oh;
    logic [NUM_QUEUES-1:0]   rdy_vec;
    logic                    cur_valid;
    logic [DATA_WIDTH-1:0]   cur_data;
    logic [CTRL_WIDTH-1:0]   cur_ctrl;
    logic                    cur_hdr;
    qidx_t                   pick_idx;
    logic                    pick_any;

    parser_input_arbiter_rr_pick #(
        .NUM_QUEUES (NUM_QUEUES)
    ) u_rr_pick (
        .req_i   (bus.in_valid),
        .last_i  (last_q),
        .grant_o (pick_idx),
        .any_o   (pick_any)
    );

    // Word of the granted queue.
    always_comb begin
        sel_oh    = '0;
        cur_valid = 1'b0;
        cur_data  = '0;
        cur_ctrl  = '0;
        for (int q = 0; q < NUM_QUEUES; q++) begin
            if (sel_q == qidx_t'(q)) begin
                sel_oh[q] = 1'b1;
                cur_valid = bus.in_valid[q];
                cur_data  = bus.in_data[q*DATA_WIDTH +: DATA_WIDTH];
                cur_ctrl  = bus.in_ctrl[q*CTRL_WIDTH +: CTRL_WIDTH];
            end
        end
    end

    assign cur_hdr = is_hdr(CTRL_MAX_W'(cur_ctrl));
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        drain_pay_d = drain_pay_q;
        out_data_d  = out_data_q;
        out_ctrl_d  = out_ctrl_q;
        out_wr_d    = 1'b0;
        pkt_err_d   = 1'b0;
        rdy_vec     = '0;

        unique case (state_q)
            ST_IDLE: begin
                // Arbitration cycle: nothing is consumed here.
                if (pick_any) begin
                    sel_d       = pick_idx;
                    last_d      = pick_idx;
                    cnt_d       = '0;
                    drain_pay_d = 1'b0;
                    state_d     = ST_HDR;
                end
            end

            ST_HDR, ST_DATA: begin
                if (bus.out_rdy) begin
                    rdy_vec = sel_oh;
                end
                if (cur_valid && bus.out_rdy) begin
                    out_wr_d   = 1'b1;
                    out_data_d = cur_data;
                    out_ctrl_d = cur_ctrl;
                    cnt_d      = cnt_inc;
                    if (state_q == ST_DATA && cur_hdr) begin
                        state_d = ST_IDLE;
                    end else if (cnt_inc == CNT_MAX) begin
                        // Watchdog: this word still goes out, the rest is dropped.
                        pkt_err_d   = 1'b1;
                        state_d     = ST_DRAIN;
                        drain_pay_d = (state_q == ST_DATA) || !cur_hdr;
                    end else if (!cur_hdr) begin
                        state_d = ST_DATA;
                    end
                end
            end

            ST_DRAIN: begin
                // Consume regardless of out_rdy; only a post-payload marker ends it.
                rdy_vec = sel_oh;
                if (cur_valid) begin
                    if (drain_pay_q && cur_hdr) begin
                        state_d = ST_IDLE;
                    end else if (!cur_hdr) begin
                        drain_pay_d = 1'b1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Output register stage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            last_q      <= qidx_t'(NUM_QUEUES - 1);
            cnt_q       <= '0;
            drain_pay_q <= 1'b0;
            out_data_q  <= '0;
            out_ctrl_q  <= '0;
            out_wr_q    <= 1'b0;
            pkt_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            drain_pay_q <= drain_pay_d;
            out_data_q  <= out_data_d;
            out_ctrl_q  <= out_ctrl_d;
            out_wr_q    <= out_wr_d;
            pkt_err_q   <= pkt_err_d;
        end
    end

    assign bus.in_rdy       = rdy_vec;
    assign bus.out_data     = out_data_q;
    assign bus.out_ctrl     = out_ctrl_q;
    assign bus.out_wr       = out_wr_q;
    assign bus.pkt_err      = pkt_err_q;
    assign bus.out_src_port = NUM_IQ_BITS'(sel_q);

endmodule

// File: tb/tb_parser_input_arbiter.sv
// -----------------------------------------------------------------------------
// tb_parser_input_arbiter
// Randomized bench for parser_input_arbiter. Per-queue packet lists feed the
// DUT; a packet-level reference model (round-robin over non-empty queues,
// one arbitration cycle per packet, first MAX_WORDS words forwarded) predicts
// in_rdy and the registered output stream.
// -----------------------------------------------------------------------------
module tb_parser_input_arbiter;

    localparam int DW   = 64;
    localparam int CW   = 8;
    localparam int NQ   = 4;
    localparam int IQB  = 3;
    localparam int MAXW = 8;

    typedef struct {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } word_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    parser_input_arbiter_if #(
        .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .NUM_QUEUES(NQ), .NUM_IQ_BITS(IQB)
    ) bus ();

    parser_input_arbiter #(
        .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .NUM_QUEUES(NQ), .NUM_IQ_BITS(IQB),
        .MAX_WORDS(MAXW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // pending packets per queue
    word_t wq   [NQ][$];
    int    lenq [NQ][$];

    // reference model state
    bit            m_granted = 1'b0;
    int            m_owner   = 0;
    int            m_last    = NQ - 1;
    int            m_idx     = 0;
    logic          exp_wr    = 1'b0;
    logic          exp_err   = 1'b0;
    logic [DW-1:0] exp_d     = '0;
    logic [CW-1:0] exp_c     = '0;
    int            exp_src   = 0;

    // stimulus knobs
    int   vld_pct    = 100;
    int   rdy_pct    = 100;
    int   inject_pct = 0;
    int   inject_left = 0;
    bit   rdy_toggle = 1'b0;
    logic cur_rdy    = 1'b1;

    // output monitor
    int   obs_src[$];
    int   obs_gap[$];
    bit   started   = 1'b0;
    int   gap       = 0;
    int   err_seen  = 0;
    int   words_out = 0;
    logic prev_wr   = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic add_pkt(input int q, input int len, input int nhdr);
        word_t w;
        for (int i = 0; i < len; i++) begin
            w.d = {$urandom, $urandom};
            if (i < nhdr)          w.c = CW'($urandom_range(1, 255));
            else if (i == len - 1) w.c = 8'h80;
            else                   w.c = '0;
            wq[q].push_back(w);
        end
        lenq[q].push_back(len);
    endtask

    task automatic add_rand_pkt(input int q);
        int len;
        int nh;
        len = int'($urandom_range(3, 12));
        nh  = (len > 3) ? int'($urandom_range(1, 2)) : 1;
        add_pkt(q, len, nh);
    endtask

    function automatic int pending();
        int s;
        s = m_granted ? 1 : 0;
        for (int q = 0; q < NQ; q++) s += wq[q].size();
        return s;
    endfunction

    task automatic clear_mon();
        obs_src.delete();
        obs_gap.delete();
        started   = 1'b0;
        gap       = 0;
        err_seen  = 0;
        words_out = 0;
        prev_wr   = 1'b0;
    endtask

    // One clock: check registered outputs, drive inputs, predict in_rdy.
    task automatic step();
        logic [NQ*DW-1:0] dv;
        logic [NQ*CW-1:0] cv;
        logic [NQ-1:0]    vv;
        logic [NQ-1:0]    erdy;
        logic             nwr;
        logic             nerr;
        logic             drain;
        int               len;
        int               q;
        word_t            w;

        @(negedge clk);
        check_eq("out_wr", 64'(bus.out_wr), 64'(exp_wr));
        if (exp_wr) begin
            check_eq("out_data", bus.out_data, exp_d);
            check_eq("out_ctrl", 64'(bus.out_ctrl), 64'(exp_c));
        end
        check_eq("out_src_port", 64'(bus.out_src_port), 64'(exp_src));
        check_eq("pkt_err", 64'(bus.pkt_err), 64'(exp_err));

        if (bus.pkt_err) err_seen++;
        if (bus.out_wr) begin
            words_out++;
            if (!prev_wr) begin
                obs_src.push_back(int'(bus.out_src_port));
                if (started) obs_gap.push_back(gap);
                started = 1'b1;
            end
            gap = 0;
        end else begin
            gap++;
        end
        prev_wr = bus.out_wr;

        if (inject_left > 0 && int'($urandom_range(0, 99)) < inject_pct) begin
            add_rand_pkt(int'($urandom_range(0, NQ - 1)));
            inject_left--;
        end

        for (int i = 0; i < NQ; i++) begin
            if (wq[i].size() > 0) begin
                dv[i*DW +: DW] = wq[i][0].d;
                cv[i*CW +: CW] = wq[i][0].c;
                // Only words after the first of the owner's packet may stall.
                if (m_granted && i == m_owner && m_idx > 0)
                    vv[i] = (int'($urandom_range(0, 99)) < vld_pct);
                else
                    vv[i] = 1'b1;
            end else begin
                dv[i*DW +: DW] = {$urandom, $urandom};
                cv[i*CW +: CW] = CW'($urandom);
                vv[i] = 1'b0;
            end
        end
        if (rdy_toggle) cur_rdy = ~cur_rdy;
        else            cur_rdy = (int'($urandom_range(0, 99)) < rdy_pct);
        bus.in_data  = dv;
        bus.in_ctrl  = cv;
        bus.in_valid = vv;
        bus.out_rdy  = cur_rdy;
        #1;

        erdy = '0;
        nwr  = 1'b0;
        nerr = 1'b0;
        if (!m_granted) begin
            for (int k = 1; k <= NQ; k++) begin
                q = (m_last + k) % NQ;
                if (!m_granted && lenq[q].size() > 0) begin
                    m_granted = 1'b1;
                    m_owner   = q;
                    m_last    = q;
                    m_idx     = 0;
                    exp_src   = q;
                end
            end
        end else begin
            len   = lenq[m_owner][0];
            drain = (m_idx >= MAXW);
            erdy[m_owner] = drain ? 1'b1 : cur_rdy;
            if (vv[m_owner] && erdy[m_owner]) begin
                w = wq[m_owner].pop_front();
                m_idx++;
                if (!drain) begin
                    nwr   = 1'b1;
                    exp_d = w.d;
                    exp_c = w.c;
                end
                if (m_idx == MAXW && len > MAXW) nerr = 1'b1;
                if (m_idx == len) begin
                    void'(lenq[m_owner].pop_front());
                    m_granted = 1'b0;
                end
            end
        end
        check_eq("in_rdy", 64'(bus.in_rdy), 64'(erdy));
        exp_wr  = nwr;
        exp_err = nerr;
    endtask

    task automatic run_until_empty(input int budget);
        int n;
        n = 0;
        while (pending() > 0 && n < budget) begin
            step();
            n++;
        end
        check_eq("phase_drained", 64'(pending()), 64'd0);
        step();
        step();
    endtask

    task automatic check_grants(input string tag, input int exp_seq[$]);
        check_eq({tag, "_count"}, 64'(obs_src.size()), 64'(exp_seq.size()));
        for (int i = 0; i < exp_seq.size() && i < obs_src.size(); i++)
            check_eq({tag, "_src"}, 64'(obs_src[i]), 64'(exp_seq[i]));
    endtask

    task automatic check_gaps_one(input string tag, input int n_exp);
        check_eq({tag, "_gaps"}, 64'(obs_gap.size()), 64'(n_exp));
        foreach (obs_gap[i]) check_eq({tag, "_bubble"}, 64'(obs_gap[i]), 64'd1);
    endtask

    task automatic do_reset_mid();
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_eq("rst_out_wr", 64'(bus.out_wr), 64'd0);
        check_eq("rst_out_data", bus.out_data, 64'd0);
        check_eq("rst_out_ctrl", 64'(bus.out_ctrl), 64'd0);
        check_eq("rst_src", 64'(bus.out_src_port), 64'd0);
        check_eq("rst_in_rdy", 64'(bus.in_rdy), 64'd0);
        for (int q = 0; q < NQ; q++) begin
            wq[q].delete();
            lenq[q].delete();
        end
        bus.in_valid = '0;
        m_granted = 1'b0;
        m_last    = NQ - 1;
        m_idx     = 0;
        exp_wr    = 1'b0;
        exp_err   = 1'b0;
        exp_src   = 0;
        @(negedge clk);
        #2 reset_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        int n;

        bus.in_data  = '0;
        bus.in_ctrl  = '0;
        bus.in_valid = '1;
        bus.out_rdy  = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("reset_out_wr", 64'(bus.out_wr), 64'd0);
        check_eq("reset_out_data", bus.out_data, 64'd0);
        check_eq("reset_out_ctrl", 64'(bus.out_ctrl), 64'd0);
        check_eq("reset_src", 64'(bus.out_src_port), 64'd0);
        check_eq("reset_pkt_err", 64'(bus.pkt_err), 64'd0);
        check_eq("reset_in_rdy", 64'(bus.in_rdy), 64'd0);
        bus.in_valid = '0;
        #2 reset_n = 1'b1;

        // All queues busy with 3-word packets: strict 0,1,2,3 rotation.
        for (int r = 0; r < 2; r++)
            for (int q = 0; q < NQ; q++) add_pkt(q, 3, 1);
        clear_mon();
        run_until_empty(200);
        check_grants("rr_all", '{0, 1, 2, 3, 0, 1, 2, 3});
        check_gaps_one("rr_all", 7);

        // Single packet on queue 2: 1 header, 3 payload, EOP.
        add_pkt(2, 5, 1);
        clear_mon();
        run_until_empty(50);
        check_grants("single_q2", '{2});
        check_eq("single_q2_words", 64'(words_out), 64'd5);

        // out_rdy toggling every cycle.
        rdy_toggle = 1'b1;
        add_pkt(1, 7, 2);
        clear_mon();
        run_until_empty(100);
        check_eq("toggle_words", 64'(words_out), 64'd7);
        rdy_toggle = 1'b0;

        // Runaway 12-word packet on queue 1 with an 8-word watchdog.
        add_pkt(1, 12, 1);
        clear_mon();
        run_until_empty(100);
        check_eq("wd_words", 64'(words_out), 64'd8);
        check_eq("wd_pkt_err_pulses", 64'(err_seen), 64'd1);

        // Queue 3 alone twice: re-granted after wrap, single bubble.
        add_pkt(3, 4, 1);
        add_pkt(3, 3, 1);
        clear_mon();
        run_until_empty(100);
        check_grants("wrap_q3", '{3, 3});
        check_gaps_one("wrap_q3", 1);

        // Random traffic with stalls on both sides.
        vld_pct = 70;
        rdy_pct = 60;
        for (int q = 0; q < NQ; q++) begin
            add_rand_pkt(q);
            add_rand_pkt(q);
        end
        inject_pct  = 5;
        inject_left = 30;
        clear_mon();
        run_until_empty(5000);
        inject_pct = 0;

        // Reset in the middle of a queue-2 packet, then queue 0 must win.
        vld_pct = 100;
        rdy_pct = 100;
        add_pkt(2, 10, 1);
        n = 0;
        while (!(m_granted && m_owner == 2 && m_idx >= 3) && n < 50) begin
            step();
            n++;
        end
        check_eq("mid_packet_reached", 64'(m_idx), 64'd3);
        do_reset_mid();
        add_pkt(2, 4, 1);
        add_pkt(1, 4, 1);
        add_pkt(0, 4, 1);
        clear_mon();
        run_until_empty(100);
        check_grants("after_reset", '{0, 1, 2});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/parser_input_arbiter.md
# parser_input_arbiter

Packet-granular round-robin arbiter that shares the single Ethernet-parser datapath (`in_data`/`in_ctrl`/`in_wr` of the parser stage) among NUM_QUEUES input queues. It grants one queue at a time, forwards that queue's words unchanged, and holds the grant until end of packet. It tags the forwarded packet with the granted queue index and guards against runaway packets with a word-count watchdog. It sits directly upstream of the parser, in the input-arbiter stage.

## Interface
Parameters:
- DATA_WIDTH, 64, datapath width
- CTRL_WIDTH, DATA_WIDTH/8, ctrl width
- NUM_QUEUES, 4, number of requesters (2..8)
- NUM_IQ_BITS, 3, width of queue index (≥ clog2(NUM_QUEUES))
- MAX_WORDS, 256, watchdog limit in words per packet (≥ 2)

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_data  in  NUM_QUEUES*DATA_WIDTH  queue i in bits [i*DATA_WIDTH +: DATA_WIDTH]
- in_ctrl  in  NUM_QUEUES*CTRL_WIDTH  queue i in bits [i*CTRL_WIDTH +: CTRL_WIDTH]
- in_valid  in  NUM_QUEUES  queue i presents a word
- in_rdy  out  NUM_QUEUES  word of queue i is consumed this cycle when in_valid[i] && in_rdy[i]
- out_data  out  DATA_WIDTH  to parser in_data
- out_ctrl  out  CTRL_WIDTH  to parser in_ctrl
- out_wr  out  1  to parser in_wr
- out_rdy  in  1  downstream can absorb one word issued next cycle
- out_src_port  out  NUM_IQ_BITS  index of queue owning current packet
- pkt_err  out  1  one-cycle pulse: watchdog fired

## Operation
- Packet framing: header words have ctrl≠0; first word with ctrl==0 starts payload; next word with ctrl≠0 after payload is EOP (last word).
- FSM states: IDLE, HDR, DATA, DRAIN.
- IDLE: if any in_valid, pick first requesting queue after `last_grant` (wrapping modulo NUM_QUEUES), latch `sel`, set `last_grant`=sel, go HDR. No word is consumed in IDLE.
- HDR/DATA: in_rdy[sel] = out_rdy; others 0. Accepted word (in_valid[sel] && in_rdy[sel]) is registered to out_* with out_wr=1 next cycle; otherwise out_wr=0.
- HDR→DATA on accepted word with ctrl==0. DATA→IDLE on accepted word with ctrl≠0 (EOP, forwarded).
- Word counter: cleared on grant, +1 per accepted word. If counter reaches MAX_WORDS with the accepted word not EOP: pulse pkt_err, go DRAIN.
- DRAIN: in_rdy[sel]=1 regardless of out_rdy, out_wr=0, discard words until EOP (accepted DATA-phase ctrl≠0 word) → IDLE. Downstream sees a truncated packet; that is accepted behaviour.
- out_src_port = sel, stable for the whole grant.

## Timing
- Reset values: out_wr=0, out_data=0, out_ctrl=0, out_src_port=0, pkt_err=0, in_rdy=0, state=IDLE, last_grant=NUM_QUEUES-1 (so queue 0 wins first).
- Latency: accepted word appears on out_* exactly 1 cycle later.
- Arbitration costs 1 idle cycle per packet (IDLE state); back-to-back packets from the same or different queues have exactly one bubble.
- in_rdy is combinational from state, sel, out_rdy; out_* are registered.
- out_rdy low: no words accepted, out_wr=0 next cycle, grant held.
- New requests during a grant are ignored until IDLE.
- in_valid dropping mid-packet: grant held indefinitely (no timeout on stalls; watchdog counts words only).
- reset_n asserted mid-packet: all state cleared immediately; packet fragments are the upstream's problem.

## Structure
- Shared package: FSM state enum, ctrl-word helpers (is_hdr = ctrl≠0), queue-index type.
- One sub-module: `rr_pick` — combinational round-robin selector (req vector, last_grant → grant index, any).

## Test plan
- Single packet, queue 2 only (1 hdr, 3 data, EOP ctrl=0x80): grant after 1 idle cycle, 5 words out in order, out_src_port=2, out_wr each cycle after in acceptance.
- All 4 queues requesting continuously, 3-word packets: grants 0,1,2,3,0 in sequence, one bubble between packets, no interleaving.
- out_rdy toggled every other cycle during a packet: no loss/duplication, words out only one cycle after out_rdy-high acceptance.
- MAX_WORDS=8, 12-word packet on queue 1: 8 words forwarded, pkt_err pulse once, remaining 4 words consumed with out_wr=0, then IDLE.
- reset_n low for 1 cycle in DATA: outputs zero same cycle, next grant goes to queue 0.
- Queue 3 only requester after grant 3: queue 3 re-granted (wrap), one bubble.
